// File: rtl/spi_xfer_ctrl_pkg.sv
// ============================================================================
// spi_xfer_ctrl_pkg : state encodings, default CS gaps and helpers for the SPI transfer sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_xfer_ctrl_pkg;

  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 2;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_CS_SETUP = 3'b001;
  localparam logic [2:0] ST_TX_REQ   = 3'b010;
  localparam logic [2:0] ST_TX_WAIT  = 3'b011;
  localparam logic [2:0] ST_SHIFT    = 3'b100;
  localparam logic [2:0] ST_RX_PUSH  = 3'b101;
  localparam logic [2:0] ST_CS_HOLD  = 3'b110;

  // A full RX FIFO only blocks the write when overwrite is not allowed.
  function automatic logic rx_blocked(input logic full, input logic overwrite);
    return full & ~overwrite;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_xfer_ctrl_gap.sv
// ============================================================================
// spi_gap_counter : loadable down-counter that times the CS setup/hold gaps
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_gap_counter #(
  parameter int GAP_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 soft_rst_i,
  input  logic                 load_i,
  input  logic [GAP_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [GAP_WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_count <= '0;
    end else if (soft_rst_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (dec_i && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
// ============================================================================
// spi_xfer_ctrl : burst sequencer moving words TX FIFO -> shift engine -> RX FIFO with CS gaps
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int GAP_WIDTH    = 4,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  soft_rst_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  xfer_len_i,
  input  logic                  rx_en_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  stall_o,
  output logic [CNT_WIDTH-1:0]  remaining_o,
  output logic                  ss_n_o,
  input  logic                  tx_empty_i,
  output logic                  tx_req_o,
  input  logic                  tx_resp_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ack_o,
  output logic                  shift_start_o,
  output logic [DATA_WIDTH-1:0] shift_data_o,
  input  logic                  shift_done_i,
  input  logic [DATA_WIDTH-1:0] shift_data_i,
  input  logic                  rx_full_i,
  input  logic                  rx_overwrite_i,
  output logic                  rx_req_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_ack_i
);

  localparam logic [GAP_WIDTH-1:0] c_SETUP = GAP_WIDTH'(SETUP_CYCLES);
  localparam logic [GAP_WIDTH-1:0] c_HOLD  = GAP_WIDTH'(HOLD_CYCLES);

  logic [2:0]            r_state;
  logic                  r_rx_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_stall;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic                  r_ss_n;
  logic                  r_tx_req;
  logic                  r_tx_ack;
  logic                  r_shift_start;
  logic [DATA_WIDTH-1:0] r_shift_data;
  logic                  r_rx_req;
  logic [DATA_WIDTH-1:0] r_rx_data;

  logic                  w_gap_zero;
  logic                  w_gap_load;
  logic [GAP_WIDTH-1:0]  w_gap_val;
  logic                  w_gap_dec;
  logic                  w_rx_blocked;
  logic                  w_word_done;
  logic [CNT_WIDTH-1:0]  w_rem_next;
  logic                  w_last_word;
  logic                  w_start_burst;

  assign w_start_burst = (r_state == ST_IDLE) && start_i && (xfer_len_i != '0);
  assign w_rx_blocked  = rx_blocked(rx_full_i, rx_overwrite_i);

  // A word completes on shift_done when RX is discarded, or on the accepted RX write.
  assign w_word_done = ((r_state == ST_SHIFT) && shift_done_i && !r_rx_en) ||
                       ((r_state == ST_RX_PUSH) && !w_rx_blocked && r_rx_req && rx_ack_i);
  assign w_rem_next  = r_remaining - 1'b1;
  assign w_last_word = w_word_done && (w_rem_next == '0);

  assign w_gap_load = w_start_burst || w_last_word;
  assign w_gap_val  = (r_state == ST_IDLE) ? c_SETUP : c_HOLD;
  assign w_gap_dec  = (r_state == ST_CS_SETUP) || (r_state == ST_CS_HOLD);

  spi_gap_counter #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .soft_rst_i (soft_rst_i),
    .load_i     (w_gap_load),
    .load_val_i (w_gap_val),
    .dec_i      (w_gap_dec),
    .zero_o     (w_gap_zero)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state       <= ST_IDLE;
      r_rx_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stall       <= 1'b0;
      r_remaining   <= '0;
      r_ss_n        <= 1'b1;
      r_tx_req      <= 1'b0;
      r_tx_ack      <= 1'b0;
      r_shift_start <= 1'b0;
      r_shift_data  <= '0;
      r_rx_req      <= 1'b0;
      r_rx_data     <= '0;
    end else if (soft_rst_i) begin
      r_state       <= ST_IDLE;
      r_rx_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stall       <= 1'b0;
      r_remaining   <= '0;
      r_ss_n        <= 1'b1;
      r_tx_req      <= 1'b0;
      r_tx_ack      <= 1'b0;
      r_shift_start <= 1'b0;
      r_shift_data  <= '0;
      r_rx_req      <= 1'b0;
      r_rx_data     <= '0;
    end else begin
      r_done        <= 1'b0;
      r_tx_ack      <= 1'b0;
      r_shift_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (xfer_len_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= xfer_len_i;
              r_rx_en     <= rx_en_i;
              r_busy      <= 1'b1;
              r_ss_n      <= 1'b0;
              r_state     <= ST_CS_SETUP;
            end
          end
        end
        ST_CS_SETUP: begin
          if (w_gap_zero) r_state <= ST_TX_REQ;
        end
        ST_TX_REQ: begin
          if (tx_empty_i) begin
            r_stall <= 1'b1;
          end else begin
            r_stall  <= 1'b0;
            r_tx_req <= 1'b1;
            r_state  <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // Dropping the request with the ack keeps the FIFO to a single read.
          if (tx_resp_i) begin
            r_shift_data  <= tx_data_i;
            r_tx_req      <= 1'b0;
            r_tx_ack      <= 1'b1;
            r_shift_start <= 1'b1;
            r_state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_done_i && r_rx_en) begin
            r_rx_data <= shift_data_i;
            r_state   <= ST_RX_PUSH;
          end
        end
        ST_RX_PUSH: begin
          if (w_rx_blocked) begin
            r_stall  <= 1'b1;
            r_rx_req <= 1'b0;
          end else begin
            r_stall  <= 1'b0;
            r_rx_req <= !(r_rx_req && rx_ack_i);
          end
        end
        ST_CS_HOLD: begin
          if (w_gap_zero) begin
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_word_done) begin
        r_remaining <= w_rem_next;
        r_state     <= w_last_word ? ST_CS_HOLD : ST_TX_REQ;
      end
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign stall_o       = r_stall;
  assign remaining_o   = r_remaining;
  assign ss_n_o        = r_ss_n;
  assign tx_req_o      = r_tx_req;
  assign tx_ack_o      = r_tx_ack;
  assign shift_start_o = r_shift_start;
  assign shift_data_o  = r_shift_data;
  assign rx_req_o      = r_rx_req;
  assign rx_data_o     = r_rx_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ============================================================================
// tb_spi_xfer_ctrl : scoreboard bench with FIFO / shift-engine models around spi_xfer_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_xfer_ctrl;

  localparam int DW    = 16;
  localparam int CW    = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          soft_rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] xfer_len_i = '0;
  logic          rx_en_i = 1'b0;
  logic          busy_o, done_o, stall_o, ss_n_o;
  logic [CW-1:0] remaining_o;
  logic          tx_empty_i = 1'b1;
  logic          tx_req_o;
  logic          tx_resp_i = 1'b0;
  logic [DW-1:0] tx_data_i = '0;
  logic          tx_ack_o, shift_start_o;
  logic [DW-1:0] shift_data_o;
  logic          shift_done_i = 1'b0;
  logic [DW-1:0] shift_data_i = '0;
  logic          rx_full_i = 1'b0;
  logic          rx_overwrite_i = 1'b0;
  logic          rx_req_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_ack_i = 1'b0;

  spi_xfer_ctrl #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .GAP_WIDTH(4), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .soft_rst_i(soft_rst_i), .start_i(start_i),
    .xfer_len_i(xfer_len_i), .rx_en_i(rx_en_i), .busy_o(busy_o), .done_o(done_o),
    .stall_o(stall_o), .remaining_o(remaining_o), .ss_n_o(ss_n_o), .tx_empty_i(tx_empty_i),
    .tx_req_o(tx_req_o), .tx_resp_i(tx_resp_i), .tx_data_i(tx_data_i), .tx_ack_o(tx_ack_o),
    .shift_start_o(shift_start_o), .shift_data_o(shift_data_o), .shift_done_i(shift_done_i),
    .shift_data_i(shift_data_i), .rx_full_i(rx_full_i), .rx_overwrite_i(rx_overwrite_i),
    .rx_req_o(rx_req_o), .rx_data_o(rx_data_o), .rx_ack_i(rx_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: TX FIFO contents and expected traffic per port.
  logic [DW-1:0] txq[$];
  logic [DW-1:0] exp_shift[$];
  logic [DW-1:0] exp_rx[$];
  int  exp_done = 0;
  int  n_done = 0, n_shift = 0, n_rx = 0, n_cs_fall = 0;
  bit  tx_hold = 1'b0;
  bit  sh_invert = 1'b0;
  bit  stall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- TX FIFO read-port model ----------------
  initial begin
    bit responded = 1'b0;
    int wait_cnt  = 0;
    forever begin
      @(posedge clk_i); #1;
      tx_resp_i = 1'b0;
      if (tx_req_o && !tx_hold && !responded && txq.size() > 0) begin
        if (wait_cnt == 0) begin
          tx_resp_i = 1'b1;
          tx_data_i = txq.pop_front();
          responded = 1'b1;
          wait_cnt  = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end
      if (!tx_req_o) responded = 1'b0;
      tx_empty_i = (txq.size() == 0);
    end
  end

  // ---------------- shift engine model ----------------
  initial begin
    bit            sh_busy = 1'b0;
    int            sh_cnt  = 0;
    logic [DW-1:0] sh_word = '0;
    forever begin
      @(posedge clk_i); #1;
      shift_done_i = 1'b0;
      if (sh_busy) begin
        if (sh_cnt == 0) begin
          shift_done_i = 1'b1;
          shift_data_i = sh_invert ? ~sh_word : sh_word;
          sh_busy      = 1'b0;
        end else begin
          sh_cnt--;
        end
      end
      if (shift_start_o) begin
        sh_busy = 1'b1;
        sh_word = shift_data_o;
        sh_cnt  = $urandom_range(0, 3);
      end
    end
  end

  // ---------------- RX FIFO write-port model ----------------
  initial begin
    bit acked = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      rx_ack_i = 1'b0;
      if (rx_req_o && !acked && !(rx_full_i && !rx_overwrite_i) && ($urandom_range(0, 1) == 1)) begin
        rx_ack_i = 1'b1;
        acked    = 1'b1;
      end
      if (!rx_req_o) acked = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int            cyc = 0, t_fall = 0, t_last = -1;
    bit            setup_armed = 1'b0;
    logic          prev_ss_n = 1'b1, prev_req = 1'b0;
    logic [CW-1:0] prev_rem = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (arst_n_i) begin
        chk("cs_vs_busy", ss_n_o, !busy_o);
        if (stall_o) stall_seen = 1'b1;
        if (shift_start_o) begin
          n_shift++;
          chk("tx_ack_with_start", tx_ack_o, 1);
          chk("tx_req_low_at_ack", tx_req_o, 0);
          if (exp_shift.size() == 0) chk("unexpected_word", 1, 0);
          else chk("shift_data", shift_data_o, exp_shift.pop_front());
        end
        if (rx_req_o && rx_ack_i && !(rx_full_i && !rx_overwrite_i)) begin
          n_rx++;
          if (exp_rx.size() == 0) chk("unexpected_rx_write", 1, 0);
          else chk("rx_data", rx_data_o, exp_rx.pop_front());
        end
        if (done_o) begin
          n_done++;
          chk("done_expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
          chk("done_cs_high", ss_n_o, 1);
        end
        if (prev_ss_n && !ss_n_o) begin
          n_cs_fall++;
          t_fall      = cyc;
          setup_armed = 1'b1;
        end
        if (setup_armed && tx_req_o && !prev_req) begin
          chk("setup_gap", cyc - t_fall, SETUP + 2);
          setup_armed = 1'b0;
        end
        if (busy_o && remaining_o == '0 && prev_rem != '0) t_last = cyc;
        if (!prev_ss_n && ss_n_o) begin
          if (t_last >= 0) chk("hold_gap", cyc - t_last, HOLD + 1);
          t_last      = -1;
          setup_armed = 1'b0;
        end
        prev_ss_n = ss_n_o;
        prev_req  = tx_req_o;
        prev_rem  = remaining_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic load_word(input logic [DW-1:0] w, input bit rxen);
    txq.push_back(w);
    exp_shift.push_back(w);
    if (rxen) exp_rx.push_back(sh_invert ? ~w : w);
  endtask

  task automatic start_burst(input int len, input bit rxen);
    @(posedge clk_i); #1;
    start_i    = 1'b1;
    xfer_len_i = CW'(len);
    rx_en_i    = rxen;
    exp_done++;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    rx_en_i    = 1'($urandom_range(0, 1));
    xfer_len_i = CW'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    chk(name, n_done != d0, 1);
  endtask

  task automatic flush_model();
    txq.delete();
    exp_shift.delete();
    exp_rx.delete();
    exp_done = 0;
  endtask

  initial begin
    int d0, s0, r0, f0, k, seen, len;
    bit rxen;
    repeat (3) @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ss_n", ss_n_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_remaining", remaining_o, 0);
    chk("rst_reqs", {tx_req_o, rx_req_o, stall_o, shift_start_o, tx_ack_o}, 0);
    chk("rst_data", {shift_data_o, rx_data_o}, 0);

    // Basic burst, RX on, loopback
    sh_invert = 1'b0;
    load_word(16'hA5A5, 1); load_word(16'h0001, 1); load_word(16'hFFFF, 1);
    d0 = n_done; s0 = n_shift; r0 = n_rx;
    start_burst(3, 1);
    wait_done(d0, 500, "basic_done_timeout");
    repeat (5) @(negedge clk_i);
    chk("basic_tx_acks", n_shift - s0, 3);
    chk("basic_rx_writes", n_rx - r0, 3);
    chk("basic_done_count", n_done - d0, 1);
    chk("basic_rx_drained", exp_rx.size(), 0);

    // TX underrun
    sh_invert = 1'b1;
    load_word(16'h1234, 0);
    d0 = n_done;
    start_burst(2, 0);
    k = 0;
    while (!stall_o && k < 200) begin @(negedge clk_i); k++; end
    chk("underrun_stall", stall_o, 1);
    chk("underrun_cs_low", ss_n_o, 0);
    chk("underrun_remaining", remaining_o, 1);
    repeat (10) @(negedge clk_i);
    chk("underrun_still_stalled", stall_o, 1);
    load_word(16'hBEEF, 0);
    wait_done(d0, 300, "underrun_done_timeout");

    // RX full without overwrite, then with overwrite
    @(posedge clk_i); #1;
    rx_full_i = 1'b1; rx_overwrite_i = 1'b0;
    load_word(16'h5A5A, 1);
    d0 = n_done; r0 = n_rx;
    start_burst(1, 1);
    k = 0;
    while (!stall_o && k < 200) begin @(negedge clk_i); k++; end
    chk("rxfull_stall", stall_o, 1);
    repeat (5) @(negedge clk_i);
    chk("rxfull_req_low", rx_req_o, 0);
    chk("rxfull_no_write", n_rx - r0, 0);
    @(posedge clk_i); #1 rx_full_i = 1'b0;
    wait_done(d0, 300, "rxfull_done_timeout");
    chk("rxfull_one_write", n_rx - r0, 1);
    @(posedge clk_i); #1;
    rx_full_i = 1'b1; rx_overwrite_i = 1'b1;
    load_word(16'hC3C3, 1); load_word(16'h3C3C, 1);
    d0 = n_done; r0 = n_rx;
    @(negedge clk_i); stall_seen = 1'b0;
    start_burst(2, 1);
    wait_done(d0, 300, "ovw_done_timeout");
    chk("ovw_no_stall", stall_seen, 0);
    chk("ovw_writes", n_rx - r0, 2);
    @(posedge clk_i); #1 rx_full_i = 1'b0; rx_overwrite_i = 1'b0;

    // Edge starts: zero length, and a start pulsed mid-burst
    d0 = n_done; f0 = n_cs_fall;
    start_burst(0, 1);
    wait_done(d0, 20, "len0_done_timeout");
    repeat (5) @(negedge clk_i);
    chk("len0_one_done", n_done - d0, 1);
    chk("len0_cs_never_low", n_cs_fall - f0, 0);
    for (int i = 0; i < 3; i++) load_word(DW'($urandom), 0);
    d0 = n_done; s0 = n_shift;
    start_burst(3, 0);
    repeat (6) @(posedge clk_i);
    #1 chk("midstart_busy", busy_o, 1);
    start_i = 1'b1; xfer_len_i = 8'd5;
    @(posedge clk_i); #1 start_i = 1'b0;
    wait_done(d0, 500, "midstart_done_timeout");
    repeat (30) @(negedge clk_i);
    chk("midstart_one_done", n_done - d0, 1);
    chk("midstart_words", n_shift - s0, 3);

    // Soft reset in SHIFT of word 2 of 4
    for (int i = 0; i < 4; i++) load_word(DW'($urandom), 1);
    d0 = n_done;
    start_burst(4, 1);
    seen = 0; k = 0;
    while (seen < 2 && k < 400) begin
      @(negedge clk_i);
      if (shift_start_o) seen++;
      k++;
    end
    chk("abort_reached_word2", seen, 2);
    @(posedge clk_i); #1;
    soft_rst_i = 1'b1;
    flush_model();
    @(posedge clk_i); #1 soft_rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", busy_o, 0);
    chk("abort_ss_n", ss_n_o, 1);
    chk("abort_remaining", remaining_o, 0);
    chk("abort_no_done", done_o, 0);
    repeat (20) @(negedge clk_i);
    chk("abort_no_late_done", n_done - d0, 0);

    // Async reset in TX_WAIT
    tx_hold = 1'b1;
    load_word(16'h0F0F, 0); load_word(16'hF0F0, 0);
    start_burst(2, 0);
    k = 0;
    while (!tx_req_o && k < 100) begin @(negedge clk_i); k++; end
    chk("arst_in_tx_wait", tx_req_o, 1);
    #2 arst_n_i = 1'b0;
    #1;
    chk("arst_ss_n", ss_n_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_remaining", remaining_o, 0);
    chk("arst_tx_req", tx_req_o, 0);
    flush_model();
    tx_hold = 1'b0;
    @(negedge clk_i); arst_n_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Randomized bursts
    for (int it = 0; it < 14; it++) begin
      len  = $urandom_range(0, 6);
      rxen = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      rx_overwrite_i = 1'($urandom_range(0, 1));
      rx_full_i      = rx_overwrite_i ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int i = 0; i < len; i++) load_word(DW'($urandom), rxen);
      d0 = n_done;
      start_burst(len, rxen);
      wait_done(d0, 3000, "rand_done_timeout");
      repeat (3) @(negedge clk_i);
      chk("rand_shift_drained", exp_shift.size(), 0);
      chk("rand_rx_drained", exp_rx.size(), 0);
    end

    repeat (10) @(negedge clk_i);
    chk("no_pending_done", exp_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
